// File: rtl/writeback_stage_param.sv
// Writeback stage: selects the register-file write value (link address, extended
// load data or ALU result), holds the CPU for LOAD_LATENCY cycles per load and
// suppresses the register write of misaligned loads.
module writeback_stage_param #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned CNT_W        = $clog2(LOAD_LATENCY + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] dcache_output,
    input  logic [2:0]      funct3,
    input  logic            reg_we,
    input  logic            mem_rr,
    input  logic            jump,
    output logic [XLEN-1:0] writeback,
    output logic            wb_we,
    output logic            load_pause,
    output logic            load_misaligned
);

    localparam int unsigned LANE_W = $clog2(XLEN / 8);
    // Counter preload; unused when LOAD_LATENCY == 1, clamped so it never wraps.
    localparam int unsigned CNT_INIT = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LANE_W-1:0]  offset;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    load_value;
    logic               width_misaligned;

    assign offset  = alu_result[LANE_W-1:0];
    assign shifted = dcache_output >> {offset, 3'b000};

    // Extract the addressed lane, extend it, and flag a width/offset mismatch.
    always_comb begin
        load_value       = '0;
        width_misaligned = 1'b0;
        case (funct3)
            3'b000: load_value = XLEN'($signed(shifted[7:0]));
            3'b001: begin
                load_value       = XLEN'($signed(shifted[15:0]));
                width_misaligned = offset[0];
            end
            3'b010: begin
                load_value       = XLEN'($signed(shifted[31:0]));
                width_misaligned = |offset[1:0];
            end
            3'b100: load_value = XLEN'(shifted[7:0]);
            3'b101: begin
                load_value       = XLEN'(shifted[15:0]);
                width_misaligned = offset[0];
            end
            3'b011: begin
                if (XLEN == 64) begin
                    load_value       = shifted;
                    width_misaligned = |offset;
                end
            end
            3'b110: begin
                if (XLEN == 64) begin
                    load_value       = XLEN'(shifted[31:0]);
                    width_misaligned = |offset[1:0];
                end
            end
            default: ;
        endcase
    end

    assign load_misaligned = mem_rr & width_misaligned;

    // Writeback source priority: link address, then load data, then ALU result.
    always_comb begin
        writeback = alu_result;
        if (jump && reg_we) begin
            writeback = pc + XLEN'(4);
        end else if (mem_rr) begin
            writeback = load_misaligned ? '0 : load_value;
        end
    end

    // Pause whenever a load is present and its data is not yet valid.
    assign load_pause = !reset && mem_rr && (state_q != StDone);
    assign wb_we      = reg_we && !load_pause && !load_misaligned && !reset;

    // Load latency FSM; the counter runs through stalls since memory keeps going.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_rr) begin
                        if (LOAD_LATENCY == 1) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                StWait: begin
                    if (!mem_rr) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (!stall || !mem_rr) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage_param.sv
// Directed bench for writeback_stage_param: four instances cover 32-bit latencies
// 3, 1 and 4 (sharing one stimulus set) and a 64-bit latency-2 configuration.
module tb_writeback_stage_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc, alu, dcache;
    logic [2:0]  f3;
    logic        reg_we, mem_rr, jump;

    logic        d_stall;
    logic [63:0] d_pc, d_alu, d_dcache;
    logic [2:0]  d_f3;
    logic        d_reg_we, d_mem_rr, d_jump;

    logic [31:0] a_wb, b_wb, c_wb;
    logic        a_we, a_pause, a_mis;
    logic        b_we, b_pause, b_mis;
    logic        c_we, c_pause, c_mis;
    logic [63:0] d_wb;
    logic        d_we, d_pause, d_mis;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage_param #(.XLEN(32), .LOAD_LATENCY(3)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc), .alu_result(alu),
        .dcache_output(dcache), .funct3(f3), .reg_we(reg_we), .mem_rr(mem_rr),
        .jump(jump), .writeback(a_wb), .wb_we(a_we), .load_pause(a_pause),
        .load_misaligned(a_mis)
    );

    writeback_stage_param #(.XLEN(32), .LOAD_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc), .alu_result(alu),
        .dcache_output(dcache), .funct3(f3), .reg_we(reg_we), .mem_rr(mem_rr),
        .jump(jump), .writeback(b_wb), .wb_we(b_we), .load_pause(b_pause),
        .load_misaligned(b_mis)
    );

    writeback_stage_param #(.XLEN(32), .LOAD_LATENCY(4)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc), .alu_result(alu),
        .dcache_output(dcache), .funct3(f3), .reg_we(reg_we), .mem_rr(mem_rr),
        .jump(jump), .writeback(c_wb), .wb_we(c_we), .load_pause(c_pause),
        .load_misaligned(c_mis)
    );

    writeback_stage_param #(.XLEN(64), .LOAD_LATENCY(2)) dut_d (
        .clk(clk), .reset(reset), .stall(d_stall), .pc(d_pc), .alu_result(d_alu),
        .dcache_output(d_dcache), .funct3(d_f3), .reg_we(d_reg_we), .mem_rr(d_mem_rr),
        .jump(d_jump), .writeback(d_wb), .wb_we(d_we), .load_pause(d_pause),
        .load_misaligned(d_mis)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled 3 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; pc = '0; alu = '0; dcache = '0; f3 = '0;
        reg_we = 0; mem_rr = 0; jump = 0;
        d_stall = 0; d_pc = '0; d_alu = '0; d_dcache = '0; d_f3 = '0;
        d_reg_we = 0; d_mem_rr = 0; d_jump = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        mem_rr = 1; reg_we = 1; f3 = 3'b010; alu = 32'h0; dcache = 32'hCAFE_F00D;
        #2;
        checks++;
        if (a_pause !== 1'b0 || a_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got pause=%b we=%b exp pause=0 we=0", a_pause, a_we);
        end
        checks++;
        if (a_wb !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL reset_wb_mux got %h exp cafef00d", a_wb);
        end
        next_cycle();
        next_cycle();
        reset = 0;
        mem_rr = 0;
        #2;
        checks++;
        if (c_pause !== 1'b0 || c_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got pause=%b we=%b exp pause=0 we=1", c_pause, c_we);
        end
        next_cycle();
    endtask

    task automatic test_lw_latency3();
        do_reset();
        mem_rr = 1; reg_we = 1; f3 = 3'b010; alu = 32'h100; dcache = 32'hDEAD_BEEF;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #2;
            checks++;
            if (a_pause !== 1'b1 || a_we !== 1'b0) begin
                errors++;
                $display("FAIL lw3_pause cyc%0d got pause=%b we=%b exp pause=1 we=0",
                         cyc, a_pause, a_we);
            end
            next_cycle();
        end
        #2;
        checks++;
        if (a_pause !== 1'b0 || a_we !== 1'b1 || a_wb !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw3_done got pause=%b we=%b wb=%h exp pause=0 we=1 wb=deadbeef",
                     a_pause, a_we, a_wb);
        end
        next_cycle();
    endtask

    task automatic test_extract();
        logic [2:0]  vf3  [10] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010,
                                   3'b001, 3'b010, 3'b011, 3'b000, 3'b110};
        logic [31:0] vadr [10] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h0,
                                   32'h1, 32'h2, 32'h0, 32'h1, 32'h0};
        logic [31:0] vdat [10] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_FFFF,
                                   32'h80FF_FFFF, 32'h1234_5678, 32'h80FF_FFFF,
                                   32'h80FF_FFFF, 32'h1234_5678, 32'h0000_7F00,
                                   32'h1234_5678};
        logic [31:0] vexp [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                                   32'hFFFF_80FF, 32'h1234_5678, 32'h0, 32'h0,
                                   32'h0, 32'h0000_007F, 32'h0};
        logic        vmis [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            mem_rr = 1; reg_we = 1; f3 = vf3[i]; alu = vadr[i]; dcache = vdat[i];
            #2;
            checks++;
            if (b_pause !== 1'b1 || b_we !== 1'b0) begin
                errors++;
                $display("FAIL extract_pause v%0d got pause=%b we=%b exp pause=1 we=0",
                         i, b_pause, b_we);
            end
            next_cycle();
            #2;
            checks++;
            if (b_wb !== vexp[i] || b_mis !== vmis[i] || b_we !== !vmis[i] ||
                b_pause !== 1'b0) begin
                errors++;
                $display("FAIL extract_v%0d got wb=%h mis=%b we=%b pause=%b exp wb=%h mis=%b we=%b pause=0",
                         i, b_wb, b_mis, b_we, b_pause, vexp[i], vmis[i], !vmis[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_jump();
        do_reset();
        jump = 1; reg_we = 1; pc = 32'hFFFF_FFFC; alu = 32'h1234;
        #2;
        checks++;
        if (b_wb !== 32'h0 || b_we !== 1'b1 || b_pause !== 1'b0) begin
            errors++;
            $display("FAIL jalr_wrap got wb=%h we=%b pause=%b exp wb=0 we=1 pause=0",
                     b_wb, b_we, b_pause);
        end
        next_cycle();
        reg_we = 0;
        #2;
        checks++;
        if (b_wb !== 32'h1234 || b_we !== 1'b0) begin
            errors++;
            $display("FAIL jump_no_rd got wb=%h we=%b exp wb=1234 we=0", b_wb, b_we);
        end
        next_cycle();
        jump = 0; reg_we = 1; alu = 32'h1; f3 = 3'b001;
        #2;
        checks++;
        if (b_wb !== 32'h1 || b_we !== 1'b1 || b_mis !== 1'b0) begin
            errors++;
            $display("FAIL alu_path got wb=%h we=%b mis=%b exp wb=1 we=1 mis=0",
                     b_wb, b_we, b_mis);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        logic exp_pause;
        do_reset();
        mem_rr = 1; reg_we = 1; f3 = 3'b010; alu = 32'h40; dcache = 32'hA5A5_0001;
        for (int cyc = 0; cyc < 8; cyc++) begin
            stall = (cyc >= 2 && cyc <= 6);
            exp_pause = (cyc < 4);
            #2;
            checks++;
            if (c_pause !== exp_pause || c_we !== !exp_pause) begin
                errors++;
                $display("FAIL stall_seq cyc%0d got pause=%b we=%b exp pause=%b we=%b",
                         cyc, c_pause, c_we, exp_pause, !exp_pause);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pause;
        // Continues straight from test_stall: cycle 8 is the next load.
        for (int cyc = 0; cyc < 5; cyc++) begin
            exp_pause = (cyc < 4);
            #2;
            checks++;
            if (c_pause !== exp_pause) begin
                errors++;
                $display("FAIL b2b_pause cyc%0d got %b exp %b", cyc, c_pause, exp_pause);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_load();
        logic exp_pause;
        do_reset();
        mem_rr = 1; reg_we = 1; f3 = 3'b010; alu = 32'h80; dcache = 32'h0;
        next_cycle();
        reset = 1;
        #2;
        checks++;
        if (c_pause !== 1'b0 || c_we !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got pause=%b we=%b exp 0 0", c_pause, c_we);
        end
        next_cycle();
        reset = 0; mem_rr = 0;
        #2;
        checks++;
        if (c_pause !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got pause=%b exp 0", c_pause);
        end
        next_cycle();
        mem_rr = 1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            exp_pause = (cyc < 4);
            #2;
            checks++;
            if (c_pause !== exp_pause) begin
                errors++;
                $display("FAIL midreset_reload cyc%0d got %b exp %b", cyc, c_pause, exp_pause);
            end
            next_cycle();
        end
    endtask

    task automatic test_rv64();
        logic [2:0]  vf3  [5] = '{3'b110, 3'b010, 3'b011, 3'b011, 3'b111};
        logic [63:0] vadr [5] = '{64'h4, 64'h4, 64'h4, 64'h0, 64'h0};
        logic [63:0] vexp [5] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001,
                                  64'h0, 64'h8000_0001_0000_0000, 64'h0};
        logic        vmis [5] = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            d_mem_rr = 1; d_reg_we = 1; d_f3 = vf3[i]; d_alu = vadr[i];
            d_dcache = 64'h8000_0001_0000_0000;
            for (int cyc = 0; cyc < 2; cyc++) begin
                #2;
                checks++;
                if (d_pause !== 1'b1 || d_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rv64_pause v%0d cyc%0d got pause=%b we=%b exp 1 0",
                             i, cyc, d_pause, d_we);
                end
                next_cycle();
            end
            #2;
            checks++;
            if (d_wb !== vexp[i] || d_mis !== vmis[i] || d_we !== !vmis[i] ||
                d_pause !== 1'b0) begin
                errors++;
                $display("FAIL rv64_v%0d got wb=%h mis=%b we=%b pause=%b exp wb=%h mis=%b we=%b pause=0",
                         i, d_wb, d_mis, d_we, d_pause, vexp[i], vmis[i], !vmis[i]);
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        #1;
        test_reset();
        test_lw_latency3();
        test_extract();
        test_jump();
        test_stall();
        test_back_to_back();
        test_reset_mid_load();
        test_rv64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage_param.md
Name: writeback_stage_param

Overview:
Parametrised final pipeline stage of the RISC-V core. It selects the register-file writeback value from the link address (pc+4), the extracted and sign/zero-extended load data, or the ALU result. For loads it holds the CPU for a configurable number of memory-latency cycles. It also detects misaligned loads and suppresses their register write.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
LOAD_LATENCY, 1, cycles load_pause is held per load (>=1); 1 reproduces the current single-cycle pause.
CNT_W, $clog2(LOAD_LATENCY+1), latency counter width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  downstream/memory stall; stage holds while high
pc  input  XLEN  PC of the instruction in writeback
alu_result  input  XLEN  ALU result; also the load address
dcache_output  input  XLEN  raw aligned word from data memory
funct3  input  3  load width/sign selector
reg_we  input  1  instruction writes rd
mem_rr  input  1  instruction is a load
jump  input  1  JAL/JALR
writeback  output  XLEN  value to the register file
wb_we  output  1  qualified register write enable
load_pause  output  1  CPU must hold this instruction
load_misaligned  output  1  current load address misaligned for its width

Behaviour:
- Lane width: LANE_W = log2(XLEN/8). Byte offset = alu_result[LANE_W-1:0]. Lane shift = offset*8.
- funct3 decoding:
  - 000 LB, 001 LH, 010 LW: sign-extend.
  - 100 LBU, 101 LHU: zero-extend.
  - XLEN=64 only: 011 LD, 110 LWU.
  - Any other code: extracted value 0, no misalignment.
  - For XLEN=64, LW sign-extends from bit 31.
- Misalignment (combinational, asserted only with mem_rr=1):
  - LH/LHU with offset[0]=1.
  - LW/LWU with offset[1:0]!=0.
  - LD with offset[2:0]!=0.
- Writeback mux priority:
  1. jump & reg_we -> pc + 4, modulo 2^XLEN.
  2. mem_rr -> extracted load value, forced to 0 if misaligned.
  3. Otherwise alu_result.
- FSM states: IDLE, WAIT, DONE. Counter cnt (CNT_W bits).
  - IDLE:
    - load_pause = mem_rr.
    - If mem_rr: go to DONE when LOAD_LATENCY==1; otherwise go to WAIT with cnt = LOAD_LATENCY-2.
  - WAIT:
    - load_pause = mem_rr.
    - If !mem_rr (flush): go to IDLE.
    - Else if cnt==0: go to DONE.
    - Else: cnt decrements.
    - cnt counts regardless of stall, because memory progresses independently.
  - DONE:
    - load_pause = 0; data is valid.
    - If !stall or !mem_rr: go to IDLE.
    - Else: stay in DONE.
- Resulting latency: a load asserts load_pause for exactly LOAD_LATENCY consecutive cycles from its first cycle in writeback, then deasserts.
- wb_we = reg_we & !load_pause & !load_misaligned & !reset.
- Back-to-back loads: from DONE with !stall, the FSM returns to IDLE. The next load pauses again for the full LOAD_LATENCY.
- Reset:
  - Synchronous; state=IDLE, cnt=0 on the next edge, including mid-load.
  - While reset is high: load_pause=0, wb_we=0, writeback follows the combinational mux.
- Simultaneous reset and mem_rr: reset wins; state is IDLE next cycle.

Test Plan:
- XLEN=32, LOAD_LATENCY=3; LW at addr 0x100, dcache_output=0xDEADBEEF, stall=0 -> load_pause high for cycles 0-2. Cycle 3: writeback=0xDEADBEEF, wb_we=1.
- XLEN=32, LATENCY=1; LB addr 0x3, dcache_output=0x80FF_FFFF -> writeback=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x2 -> 0x000080FF.
- LH at addr 0x1 -> load_misaligned=1, writeback=0, wb_we=0 after the pause. LW at addr 0x2 -> same.
- JALR with reg_we=1, pc=0xFFFFFFFC -> writeback=0x00000000 (wrap), wb_we=1, load_pause=0.
- LATENCY=4: stall=1 held from cycle 2 to 6 -> pause cycles 0-3, then FSM stays in DONE through cycle 6, returns to IDLE at cycle 7. Reset asserted at cycle 1 of a new load -> IDLE next cycle, load_pause=0.
- XLEN=64, LATENCY=2: LWU addr 0x4, dcache_output=0x8000_0001_0000_0000 -> 0x0000_0000_8000_0001. LW same -> 0xFFFF_FFFF_8000_0001. LD addr 0x4 -> misaligned.
